mem_access_seq: RTL and testbench

// - Memory sequencer + instruction register between the multicycle control FSM and unified instr/data memory.
// - Takes one access request per instruction step and counts memory wait states, replacing hard-coded wait states in the control FSM.
// - Returns a one-cycle done pulse and registered read data. On fetches, latches the instruction word and splits it into fields (opcode feeds control).

---
 rtl/mem_access_seq_pkg.sv | 26 ++
 rtl/mem_access_seq_if.sv | 32 +++
 rtl/mem_access_seq_ir_fields.sv | 21 ++
 rtl/mem_access_seq.sv | 118 +++++++++++
 tb/tb_mem_access_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_seq_pkg.sv
// Shared definitions for the memory access sequencer: instruction field positions,
// opcode constants and the sequencer state encoding.
package mem_access_seq_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } seq_state_t;

endpackage

// File: rtl/mem_access_seq_if.sv
// Request/completion bus between the control FSM and the sequencer, plus the memory port.
interface mem_access_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // req is sampled only while the sequencer is idle (busy=0); a request completes with a
  // one-cycle done pulse, or is refused with a one-cycle err pulse when addr is not word-aligned.
  logic              req;
  logic              we;
  logic              is_fetch;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req, we, is_fetch, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_wdata, mem_wr
  );

  modport slave (
    input  req, we, is_fetch, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_wdata, mem_wr
  );

endinterface

// File: rtl/mem_access_seq_ir_fields.sv
// Combinational split of a 32-bit instruction word into its fields; also used by the decoder.
module mem_access_seq_ir_fields
  import mem_access_seq_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm
);

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign funct  = ir[FUNCT_HI:FUNCT_LO];
  assign imm    = ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/mem_access_seq.sv
// Memory sequencer and instruction register: one access per request, counts memory wait
// states, returns a done pulse with registered read data and latches fetched instructions.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 3,
  parameter int WR_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_seq_if.slave bus,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output seq_state_t  state
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LATENCY - 1);

  if (RD_LATENCY < 1 || WR_LATENCY < 1 || DATA_W != 32) begin : g_param_err
    $error("mem_access_seq: latencies must be >= 1 and DATA_W must be 32");
  end

  seq_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [31:0]       ir_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] mwdata_q;
  logic              mwr_q;
  logic              we_q;
  logic              fetch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ir_q     <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwr_q    <= 1'b0;
      we_q     <= 1'b0;
      fetch_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            if (bus.addr[1:0] != 2'b00) begin
              err_q <= 1'b1;
            end else begin
              maddr_q  <= bus.addr;
              mwdata_q <= bus.wdata;
              mwr_q    <= bus.we;
              we_q     <= bus.we;
              fetch_q  <= bus.is_fetch & ~bus.we;
              cnt_q    <= bus.we ? WR_CNT : RD_CNT;
              busy_q   <= 1'b1;
              state_q  <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Requests arriving here are deliberately dropped; memory bus stays stable.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            if (!we_q) begin
              rdata_q <= bus.mem_rdata;
              if (fetch_q) ir_q <= bus.mem_rdata;
            end
            mwr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.mem_wr    = mwr_q;
  assign state         = state_q;

  mem_access_seq_ir_fields u_fields (
    .ir     (ir_q),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .funct  (funct),
    .imm    (imm)
  );

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: reads, fetches, writes, misalignment, busy requests, reset abort.
module tb_mem_access_seq;
  import mem_access_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  seq_state_t  state;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  mem_access_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_seq #(
    .ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .WR_LATENCY(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .funct  (funct),
    .imm    (imm),
    .state  (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_rdata(input string tag);
    if (exp_q.size() == 0) begin
      check_val({tag, "_exp_q_empty"}, 32'd0, 32'd1);
    end else begin
      check_val(tag, bus.rdata, exp_q.pop_front());
    end
  endtask

  task automatic drive_req(input logic w, input logic f, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] md);
    bus.req       = 1'b1;
    bus.we        = w;
    bus.is_fetch  = f;
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_rdata = md;
    if (!w && a[1:0] == 2'b00) exp_q.push_back(md);
  endtask

  // Issues one request, then waits (bounded) for done, counting busy and mem_wr cycles.
  task automatic run_access(input logic w, input logic f, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] md,
                            output int nbusy, output int nwr,
                            output logic [31:0] wr_addr, output logic [31:0] wr_data);
    drive_req(w, f, a, d, md);
    tick();
    bus.req = 1'b0;
    nbusy = 0;
    nwr = 0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (bus.busy) nbusy++;
      if (bus.mem_wr) begin
        nwr++;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_wdata;
      end
      tick();
    end
    check_val("done_seen", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int nbusy;
    int nwr;
    logic [31:0] wa;
    logic [31:0] wd;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.is_fetch = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    check_val("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check_val("rst_rdata", bus.rdata, 32'd0);
    check_val("rst_mem_addr", bus.mem_addr, 32'd0);
    check_val("rst_opcode", 32'(opcode), 32'd0);
    check_val("rst_state", 32'(state), 32'(ST_IDLE));

    // 1. data read
    run_access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, nbusy, nwr, wa, wd);
    check_val("rd_busy_cycles", 32'(nbusy), 32'd3);
    check_val("rd_mem_wr_cycles", 32'(nwr), 32'd0);
    check_val("rd_mem_addr", bus.mem_addr, 32'h10);
    check_rdata("rd_rdata");
    check_val("rd_ir_unchanged", 32'(opcode), 32'd0);
    tick();
    check_val("rd_done_one_cycle", 32'(bus.done), 32'd0);

    // 2. instruction fetch: addi $t1,$zero,5
    run_access(1'b0, 1'b1, 32'h4, 32'h0, 32'h2009_0005, nbusy, nwr, wa, wd);
    check_val("fe_busy_cycles", 32'(nbusy), 32'd3);
    check_rdata("fe_rdata");
    check_val("fe_opcode", 32'(opcode), 32'h08);
    check_val("fe_rs", 32'(rs), 32'd0);
    check_val("fe_rt", 32'(rt), 32'd9);
    check_val("fe_rd", 32'(rd), 32'd0);
    check_val("fe_funct", 32'(funct), 32'h05);
    check_val("fe_imm", 32'(imm), 32'h0005);
    tick();

    // 3. write
    run_access(1'b1, 1'b0, 32'h20, 32'h1234, 32'hFFFF_FFFF, nbusy, nwr, wa, wd);
    check_val("wr_mem_wr_cycles", 32'(nwr), 32'd1);
    check_val("wr_busy_cycles", 32'(nbusy), 32'd1);
    check_val("wr_mem_addr", wa, 32'h20);
    check_val("wr_mem_wdata", wd, 32'h1234);
    check_val("wr_mem_wr_dropped", 32'(bus.mem_wr), 32'd0);
    check_val("wr_rdata_kept", bus.rdata, 32'h2009_0005);
    check_val("wr_ir_kept", 32'(opcode), 32'h08);
    tick();

    // 4. misaligned request
    drive_req(1'b1, 1'b0, 32'h13, 32'hAAAA, 32'h0);
    tick();
    bus.req = 1'b0;
    check_val("mis_err", 32'(bus.err), 32'd1);
    check_val("mis_busy", 32'(bus.busy), 32'd0);
    check_val("mis_mem_wr", 32'(bus.mem_wr), 32'd0);
    check_val("mis_state", 32'(state), 32'(ST_IDLE));
    tick();
    check_val("mis_err_pulse", 32'(bus.err), 32'd0);
    check_val("mis_mem_wr_after", 32'(bus.mem_wr), 32'd0);

    // 5. request while busy is ignored; request on the done cycle is accepted
    drive_req(1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFE_0001);
    tick();
    bus.req = 1'b1;
    bus.addr = 32'h44;
    tick();
    bus.req = 1'b0;
    check_val("bz_addr_stable", bus.mem_addr, 32'h40);
    check_val("bz_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 20 && !bus.done; i++) tick();
    check_val("bz_done", 32'(bus.done), 32'd1);
    check_rdata("bz_rdata");
    drive_req(1'b0, 1'b0, 32'h48, 32'h0, 32'h0BAD_F00D);
    tick();
    bus.req = 1'b0;
    check_val("b2b_busy", 32'(bus.busy), 32'd1);
    check_val("b2b_addr", bus.mem_addr, 32'h48);
    nbusy = 0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (bus.busy) nbusy++;
      tick();
    end
    check_val("b2b_done", 32'(bus.done), 32'd1);
    check_val("b2b_busy_cycles", 32'(nbusy), 32'd3);
    check_rdata("b2b_rdata");
    check_val("b2b_ir_kept", 32'(opcode), 32'h08);
    repeat (4) tick();
    check_val("b2b_no_phantom_busy", 32'(bus.busy), 32'd0);
    check_val("b2b_no_phantom_done", 32'(bus.done), 32'd0);

    // 6. reset aborts an in-flight write
    drive_req(1'b1, 1'b0, 32'h30, 32'h55, 32'h0);
    tick();
    bus.req = 1'b0;
    check_val("ab_mem_wr_on", 32'(bus.mem_wr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("ab_mem_wr_off", 32'(bus.mem_wr), 32'd0);
    check_val("ab_done", 32'(bus.done), 32'd0);
    check_val("ab_busy", 32'(bus.busy), 32'd0);
    check_val("ab_rdata", bus.rdata, 32'd0);
    check_val("ab_opcode", 32'(opcode), 32'd0);
    check_val("ab_mem_addr", bus.mem_addr, 32'd0);
    tick();
    check_val("ab_no_late_done", 32'(bus.done), 32'd0);
    run_access(1'b0, 1'b0, 32'h50, 32'h0, 32'h1357_2468, nbusy, nwr, wa, wd);
    check_val("ab_next_busy_cycles", 32'(nbusy), 32'd3);
    check_rdata("ab_next_rdata");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
